// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, arbiter states and the
// default flit width used by the injection path.
package noc_pkg;

  localparam int unsigned FLIT_W_DEF = 34;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Takes the two type bits from the top of a flit.
  function automatic flit_type_e flit_type(input logic [1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ, found by scanning a doubled request vector.
module rr_pick
  import noc_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;

  assign dbl = {req, req};

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < 2 * NREQ; i++) begin
      if (!any && (i >= 32'(ptr)) && dbl[i]) begin
        any = 1'b1;
        idx = IDW'(i % NREQ);
      end
    end
    gnt = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter feeding a router local input through one
// registered slice. Optional protocol checking under NOC_ARB_PROTO_CHECK_EN.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = FLIT_W_DEF,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*FLIT_W-1:0] req_flit,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]      lin_flit,
  output logic                   lin_valid,
  input  logic                   lin_ready,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   err,
  output logic [IDW-1:0]         err_id
);

  arb_state_e        state, state_n;
  logic [IDW-1:0]    ptr, owner, sel, sel_inc, pick_idx;
  logic [NREQ-1:0]   pick_gnt;
  logic              pick_any, slot_free, sel_valid, accept, fwd;
  logic [FLIT_W-1:0] sel_flit;
  flit_type_e        ft;
`ifdef NOC_ARB_PROTO_CHECK_EN
  logic              err_set;
`endif

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign slot_free = !lin_valid || lin_ready;
  assign sel       = (state == ARB_LOCKED) ? owner : pick_idx;
  assign sel_valid = (state == ARB_LOCKED) ? req_valid[owner] : pick_any;
  assign sel_flit  = req_flit[sel*FLIT_W +: FLIT_W];
  assign ft        = flit_type(sel_flit[FLIT_W-1 -: 2]);
  assign accept    = sel_valid && slot_free;
  assign sel_inc   = (32'(sel) == NREQ - 1) ? '0 : sel + IDW'(1);
  assign busy      = (state == ARB_LOCKED);

  // While locked, non-owners stay blocked even when the owner is idle.
  always_comb begin
    req_ready = '0;
    if (state == ARB_IDLE) begin
      req_ready = slot_free ? pick_gnt : '0;
    end else if (accept) begin
      req_ready = NREQ'(1) << owner;
    end
  end

  always_comb begin
    state_n = state;
    fwd     = accept;
`ifdef NOC_ARB_PROTO_CHECK_EN
    err_set = 1'b0;
`endif
    unique case (state)
      ARB_IDLE: begin
        if (accept) begin
          if (ft == FT_HEAD) state_n = ARB_LOCKED;
`ifdef NOC_ARB_PROTO_CHECK_EN
          if (ft == FT_BODY || ft == FT_TAIL) begin
            fwd     = 1'b0;
            err_set = 1'b1;
          end
`endif
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          if (ft == FT_TAIL) state_n = ARB_IDLE;
`ifdef NOC_ARB_PROTO_CHECK_EN
          if (ft == FT_HEAD) err_set = 1'b1;
`endif
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      grant_id  <= '0;
      lin_flit  <= '0;
      lin_valid <= 1'b0;
    end else begin
      if (accept) begin
        grant_id <= sel;
        if (state == ARB_IDLE && ft == FT_HEAD) owner <= sel;
        // Pointer advances past whoever just finished (or consumed) a packet.
        if ((state == ARB_IDLE && ft != FT_HEAD) ||
            (state == ARB_LOCKED && ft == FT_TAIL)) ptr <= sel_inc;
      end
      if (fwd) begin
        lin_flit  <= sel_flit;
        lin_valid <= 1'b1;
      end else if (lin_ready) begin
        lin_valid <= 1'b0;
      end
    end
  end

`ifdef NOC_ARB_PROTO_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      err_id <= '0;
    end else if (err_set) begin
      err <= 1'b1;
      if (!err) err_id <= sel;
    end
  end
`else
  assign err    = 1'b0;
  assign err_id = '0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Testbench for noc_inject_arbiter (NREQ=4, FLIT_W=34); expectations follow
// NOC_ARB_PROTO_CHECK_EN when it is defined for the build.
module tb_noc_inject_arbiter;

  localparam int W  = 34;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  req_flit;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    lin_flit;
  logic            lin_valid;
  logic            lin_ready;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            err;
  logic [IW-1:0]   err_id;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference state: owner -1 means no packet in progress.
  bit         m_lv;
  logic [W-1:0] m_lf;
  int         m_owner, m_ptr, m_gid, m_sel, m_eid;
  bit         m_err;
  logic [N-1:0] m_rdy;
  int         rem[N];
  int         seq[N];

  always #5 clk = ~clk;

  noc_inject_arbiter #(.FLIT_W(W), .NREQ(N), .IDW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_flit  (req_flit),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .lin_flit  (lin_flit),
    .lin_valid (lin_valid),
    .lin_ready (lin_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err),
    .err_id    (err_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int payload);
    return {t, 32'(payload)};
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] f, input logic v);
    req_flit[i*W +: W] = f;
    req_valid[i]       = v;
  endtask

  task automatic model_reset();
    m_lv = 0; m_lf = '0; m_owner = -1; m_ptr = 0; m_gid = 0; m_err = 0; m_eid = 0;
  endtask

  task automatic model_comb();
    bit slot;
    slot  = !m_lv || lin_ready;
    m_sel = -1;
    if (m_owner >= 0) m_sel = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (m_sel < 0 && req_valid[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
    m_rdy = '0;
    if (m_sel >= 0 && req_valid[m_sel] && slot) m_rdy[m_sel] = 1'b1;
  endtask

  task automatic note_err();
    if (!m_err) m_eid = m_sel;
    m_err = 1;
  endtask

  task automatic model_update();
    logic [W-1:0] f;
    logic [1:0]   t;
    bit           fwd;
    if (m_rdy != '0) begin
      f   = req_flit[m_sel*W +: W];
      t   = f[W-1:W-2];
      fwd = 1;
      if (m_owner < 0) begin
        if (t == 2'b10) m_owner = m_sel;
        else            m_ptr = (m_sel + 1) % N;
`ifdef NOC_ARB_PROTO_CHECK_EN
        if (t == 2'b00 || t == 2'b01) begin fwd = 0; note_err(); end
`endif
      end else begin
        if (t == 2'b01) begin m_owner = -1; m_ptr = (m_sel + 1) % N; end
`ifdef NOC_ARB_PROTO_CHECK_EN
        if (t == 2'b10) note_err();
`endif
      end
      m_gid = m_sel;
      if (fwd) begin m_lv = 1; m_lf = f; end
      else if (lin_ready) m_lv = 0;
    end else if (lin_ready) begin
      m_lv = 0;
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    #3;
    model_comb();
    chk("req_ready", req_ready, m_rdy);
    chk("lin_valid", lin_valid, m_lv);
    chk("lin_flit",  lin_flit,  m_lf);
    chk("busy",      busy,      m_owner >= 0);
    chk("grant_id",  grant_id,  m_gid);
    chk("err",       err,       m_err);
    chk("err_id",    err_id,    m_eid);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int i);
    logic [1:0] t;
    int len;
    if (rem[i] == 0) begin
      len = $urandom_range(1, 4);
      if (len == 1) t = 2'b11;
      else begin t = 2'b10; rem[i] = len - 1; end
    end else if (rem[i] == 1) begin
      t = 2'b01; rem[i] = 0;
    end else begin
      t = 2'b00; rem[i]--;
    end
    seq[i]++;
    set_req(i, mk(t, (i << 24) | seq[i]), 1'b1);
  endtask

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; req_flit = '0; req_valid = '0; lin_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_lin_valid", lin_valid, 0);
    chk("rst_lin_flit",  lin_flit,  0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id",  grant_id,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_err",       err,       0);
    chk("rst_err_id",    err_id,    0);
    rst = 1'b0;

    // Single flit from req0
    set_req(0, mk(2'b11, 32'h0000_00AA), 1'b1);
    step();
    set_req(0, '0, 1'b0);
    chk("single_lv",   lin_valid, 1);
    chk("single_flit", lin_flit,  mk(2'b11, 32'h0000_00AA));
    chk("single_busy", busy,      0);

    // Round robin, pointer now at 1
    for (int i = 0; i < N; i++) set_req(i, mk(2'b11, 32'h100 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_grant", grant_id, (1 + k) % N);
      chk("rr_lv",    lin_valid, 1);
      chk("rr_flit",  lin_flit,  mk(2'b11, 32'h100 + (1 + k) % N));
    end
    req_valid = '0;
    step();

    // Lock: req1 packet while req2 waits (pointer at 2)
    set_req(1, mk(2'b10, 32'h1_0000), 1'b1);
    step();
    set_req(2, mk(2'b11, 32'h2_0000), 1'b1);
    for (int b = 0; b < 3; b++) begin
      set_req(1, mk((b < 2) ? 2'b00 : 2'b01, 32'h1_0001 + b), 1'b1);
      #1;
      chk("lock_block_r2", req_ready[2], 0);
      step();
    end
    set_req(1, '0, 1'b0);
    step();
    set_req(2, '0, 1'b0);
    chk("lock_after_tail", lin_flit, mk(2'b11, 32'h2_0000));

    // Backpressure mid-packet on req3 (pointer at 3)
    set_req(3, mk(2'b10, 32'h3_0000), 1'b1);
    step();
    set_req(3, mk(2'b00, 32'h3_0001), 1'b1);
    step();
    held = mk(2'b00, 32'h3_0001);
    lin_ready = 1'b0;
    set_req(3, mk(2'b00, 32'h3_0002), 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      step();
      chk("bp_flit", lin_flit, held);
    end
    lin_ready = 1'b1;
    step();
    chk("bp_resume", lin_flit, mk(2'b00, 32'h3_0002));
    set_req(3, mk(2'b01, 32'h3_0003), 1'b1);
    step();
    chk("bp_tail", lin_flit, mk(2'b01, 32'h3_0003));
    set_req(3, '0, 1'b0);
    step();

    // Asynchronous reset after req3 HEAD
    set_req(3, mk(2'b10, 32'h3_1000), 1'b1);
    step();
    set_req(3, mk(2'b00, 32'h3_1001), 1'b1);
    set_req(0, mk(2'b11, 32'h0_1000), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_lv",   lin_valid, 0);
    chk("rst_mid_busy", busy,      0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("rst_winner",      grant_id, 0);
    chk("rst_winner_flit", lin_flit, mk(2'b11, 32'h0_1000));
    req_valid = '0;
    step();

    // Stray TAIL in IDLE from req2, then stray BODY from req0
    set_req(2, mk(2'b01, 32'h0BAD_0002), 1'b1);
    step();
    set_req(2, '0, 1'b0);
`ifdef NOC_ARB_PROTO_CHECK_EN
    chk("pc_not_fwd", lin_valid, 0);
    chk("pc_err",     err,       1);
    chk("pc_err_id",  err_id,    2);
`else
    chk("pc_fwd",     lin_valid, 1);
    chk("pc_err",     err,       0);
`endif
    set_req(0, mk(2'b00, 32'h0BAD_0000), 1'b1);
    step();
    set_req(0, '0, 1'b0);
`ifdef NOC_ARB_PROTO_CHECK_EN
    chk("pc_err_id_first", err_id, 2);
`else
    chk("pc_err_id_zero",  err_id, 0);
`endif
    step();

    // Randomized protocol-correct traffic with random backpressure
    rst = 1'b1;
    req_valid = '0;
    model_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      lin_ready = ($urandom_range(3) != 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (m_rdy[i] || !req_valid[i]) begin
          if ($urandom_range(3) == 0) req_valid[i] = 1'b0;
          else gen(i);
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
